mem_resp_multicycle: RTL and testbench
======================================

Name: mem_resp_multicycle

Overview:
- Multi-cycle responder for the CPU's instruction and data memory interface.
- The CPU (initiator) issues one read or write request with enable/wr/addr/data_in. This block holds the word array, accepts the request, and returns read data or a write acknowledge a fixed LATENCY cycles later.
- It replaces the single-cycle memory behind the CPU when the pipelined core moves to stalling memory.
- It serves one outstanding request at a time and exposes ready so the core can stall.

Parameters:
- ADDR_W, 16, byte address width; word index is addr[ADDR_W-1:1].
- DATA_W, 16, word width.
- LATENCY, 4, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  request strobe from the initiator.
- wr  input  1  1 = write, 0 = read; qualified by enable.
- addr  input  ADDR_W  byte address; bit 0 ignored.
- data_in  input  DATA_W  write data; qualified by enable & wr.
- ready  output  1  responder can accept a request this cycle.
- data_valid  output  1  one-cycle response pulse: read data or write ack.
- data_out  output  DATA_W  read data; valid only while data_valid=1 for a read.
- busy  output  1  request outstanding (equals ~ready); used for stall logic.

Behaviour:
- Reset (async assert, sync-released by the system):
  - state=IDLE, counter=0, ready=1, data_valid=0, busy=0, data_out=0.
  - Array contents are not reset.
- Acceptance: a request is accepted on a rising edge where enable=1 and ready=1. Call this edge E0.
- Requests with enable=1 and ready=0 are ignored. The initiator must hold them until ready=1; the block does not queue them.
- Write:
  - The array word addr[ADDR_W-1:1] is updated at E0 with data_in.
  - The write is acknowledged by data_valid at the same time a read would be; data_out holds its previous value.
- Read:
  - The array word is sampled at E0 into the response register.
  - data_out shows the sampled value in the data_valid cycle.
- Timing:
  - ready falls in the cycle after E0.
  - data_valid=1 and ready=1 in exactly one cycle, the cycle following edge E0+LATENCY-1. With LATENCY=4, data_valid is high in cycle 4 counting E0 as the start of cycle 1.
  - data_valid is high for exactly one cycle.
- Back-to-back: a new request presented during the data_valid cycle is accepted at the edge that ends it. That gives a sustained throughput of 1 request per LATENCY cycles.
- LATENCY=1: ready stays high and data_valid follows every accepted request by one cycle. Every cycle may accept.
- State machine (LATENCY>1):
  - IDLE: on accept, go to WAIT and load counter with LATENCY-1.
  - WAIT: decrement each cycle. At counter==1, go to RESP.
  - RESP: data_valid=1, ready=1. On accept, go to WAIT; otherwise go to IDLE.
- Address wrap: the word index is taken modulo 2^(ADDR_W-1). Byte addresses 0x0000 and 0x0001 alias.
- Read-after-write to the same address: the read is accepted after the write's E0, so it returns the new data.
- Reset mid-operation: any outstanding response is dropped and no data_valid is produced. A write accepted before reset remains committed.
- enable held high through RESP with a different addr: treated as a new request, accepted at the end of RESP.
- X on wr/addr/data_in while enable=0 has no effect.

Decomposition:
- Shared package mem_pkg: state enum {IDLE, WAIT, RESP}, MEM_LATENCY_DEFAULT=4, MEM_ADDR_W=16, MEM_DATA_W=16. The CPU stall logic uses the same package.
- Sub-module mem_array_1p: single-port word array with synchronous write and synchronous read-capture enable. The responder FSM and counter stay in the top block.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> ready=1, data_valid=0, data_out=0x0000, busy=0, held for 10 cycles with enable=0.
- Write then read: write 0xBEEF to addr 0x0010 -> data_valid pulse exactly 4 cycles after E0, ready low 3 cycles. Then read 0x0010 -> data_out=0xBEEF with the data_valid pulse 4 cycles later.
- Back-to-back: enable held high with reads of 0x0000, 0x0002, 0x0004 preloaded 0x1111/0x2222/0x3333 -> pulses every 4 cycles with data in order; no request dropped or duplicated.
- Ignored request during busy: after an accepted read of 0x0020, pulse a write of 0xDEAD to 0x0020 for 1 cycle while ready=0 -> no write occurs; a later read of 0x0020 returns the original value.
- Alias and wrap: write 0xA5A5 to 0x0007 -> a read of 0x0006 returns 0xA5A5. A write to 0xFFFE followed by a read of 0xFFFF returns the same word.
- Reset mid-operation: accept a write of 0x1234 to 0x0030, assert rst_n=0 two cycles later -> no data_valid, ready=1 immediately. After release, a read of 0x0030 returns 0x1234. Repeat with LATENCY=1 -> data_valid every cycle under continuous enable.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-interface definitions used by the responder and the CPU stall logic.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  localparam int MEM_LATENCY_DEFAULT = 4;
  localparam int MEM_ADDR_W          = 16;
  localparam int MEM_DATA_W          = 16;
  // Wide enough for the largest legal LATENCY (15).
  localparam int MEM_CNT_W           = 4;

endpackage

// File: rtl/mem_array_1p.sv
// Single-port word array: synchronous write, synchronous read capture into a reset-able register.
module mem_array_1p #(
  parameter int AW = 15,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [0:(2**AW)-1];
  logic [DW-1:0] rdata_r;

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read capture; holds its value on writes and idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DW{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_resp_multicycle.sv
// Multi-cycle memory responder: one outstanding request, response LATENCY cycles after acceptance.
module mem_resp_multicycle
  import mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
);

  localparam int                   WORD_W   = ADDR_W - 1;
  localparam logic [MEM_CNT_W-1:0] LOAD_C   = MEM_CNT_W'(LATENCY - 1);
  localparam bit                   SINGLE_C = (LATENCY == 1);

  mem_state_e           state_r;
  logic [MEM_CNT_W-1:0] cnt_r;
  logic                 ready_r;
  logic                 busy_r;
  logic                 data_valid_r;
  logic                 accept_s;
  logic                 we_s;
  logic                 re_s;
  logic                 unused_s;

  assign accept_s = enable & ready_r;
  assign we_s     = accept_s & wr;
  assign re_s     = accept_s & ~wr;
  // Byte-lane bit is irrelevant for whole-word accesses.
  assign unused_s = addr[0];

  mem_array_1p #(
    .AW (WORD_W),
    .DW (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .re    (re_s),
    .addr  (addr[ADDR_W-1:1]),
    .wdata (data_in),
    .rdata (data_out)
  );

  // Responder FSM with latency counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= {MEM_CNT_W{1'b0}};
      ready_r      <= 1'b1;
      busy_r       <= 1'b0;
      data_valid_r <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      case (state_r)
        IDLE, RESP: begin
          if (accept_s) begin
            if (SINGLE_C) begin
              state_r      <= RESP;
              data_valid_r <= 1'b1;
            end else begin
              state_r <= WAIT;
              cnt_r   <= LOAD_C;
              ready_r <= 1'b0;
              busy_r  <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_r == MEM_CNT_W'(1)) begin
            state_r      <= RESP;
            cnt_r        <= {MEM_CNT_W{1'b0}};
            ready_r      <= 1'b1;
            busy_r       <= 1'b0;
            data_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - MEM_CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {MEM_CNT_W{1'b0}};
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = ready_r;
  assign busy       = busy_r;
  assign data_valid = data_valid_r;

endmodule

// File: tb/tb_mem_resp_multicycle.sv
// Directed bench for mem_resp_multicycle at LATENCY=4 and LATENCY=1.
module tb_mem_resp_multicycle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        l4_en, l4_wr, l4_rdy, l4_dv, l4_busy;
  logic [15:0] l4_addr, l4_din, l4_dout;
  logic        l1_en, l1_wr, l1_rdy, l1_dv, l1_busy;
  logic [15:0] l1_addr, l1_din, l1_dout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs [11];

  mem_resp_multicycle #(.ADDR_W(16), .DATA_W(16), .LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(l4_en), .wr(l4_wr), .addr(l4_addr),
    .data_in(l4_din), .ready(l4_rdy), .data_valid(l4_dv), .data_out(l4_dout), .busy(l4_busy)
  );

  mem_resp_multicycle #(.ADDR_W(16), .DATA_W(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(l1_en), .wr(l1_wr), .addr(l1_addr),
    .data_in(l1_din), .ready(l1_rdy), .data_valid(l1_dv), .data_out(l1_dout), .busy(l1_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with ready=1; returns at the negedge after the pulse.
  task automatic txn4(input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] exp, input string nm);
    l4_en = 1'b1; l4_wr = w; l4_addr = a; l4_din = d;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      l4_en = 1'b0;
      chk($sformatf("%s c%0d ready", nm, c), l4_rdy, 1'b0);
      chk($sformatf("%s c%0d dv", nm, c), l4_dv, 1'b0);
      chk($sformatf("%s c%0d busy", nm, c), l4_busy, 1'b1);
    end
    @(negedge clk);
    chk({nm, " c4 dv"}, l4_dv, 1'b1);
    chk({nm, " c4 ready"}, l4_rdy, 1'b1);
    chk({nm, " c4 dout"}, l4_dout, exp);
    @(negedge clk);
    chk({nm, " c5 dv"}, l4_dv, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[2]  = '{1'b1, 16'h0007, 16'hA5A5, 16'hBEEF};
    vecs[3]  = '{1'b0, 16'h0006, 16'h0000, 16'hA5A5};
    vecs[4]  = '{1'b1, 16'hFFFE, 16'h5A5A, 16'hA5A5};
    vecs[5]  = '{1'b0, 16'hFFFF, 16'h0000, 16'h5A5A};
    vecs[6]  = '{1'b1, 16'h0000, 16'h1111, 16'h5A5A};
    vecs[7]  = '{1'b1, 16'h0002, 16'h2222, 16'h5A5A};
    vecs[8]  = '{1'b1, 16'h0004, 16'h3333, 16'h5A5A};
    vecs[9]  = '{1'b1, 16'h0020, 16'h7777, 16'h5A5A};
    vecs[10] = '{1'b0, 16'h0001, 16'h0000, 16'h1111};

    rst_n = 1'b0;
    l4_en = 1'b0; l4_wr = 1'b0; l4_addr = 16'h0000; l4_din = 16'h0000;
    l1_en = 1'b0; l1_wr = 1'b0; l1_addr = 16'h0000; l1_din = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle ready", l4_rdy, 1'b1);
      chk("idle dv", l4_dv, 1'b0);
      chk("idle dout", l4_dout, 16'h0000);
      chk("idle busy", l4_busy, 1'b0);
    end

    for (int i = 0; i < 11; i++) begin
      txn4(vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].exp_dout, $sformatf("row%0d", i));
    end

    // Back-to-back reads with enable held high.
    begin
      logic [15:0] b2b_exp [3];
      b2b_exp[0] = 16'h1111; b2b_exp[1] = 16'h2222; b2b_exp[2] = 16'h3333;
      l4_en = 1'b1; l4_wr = 1'b0; l4_addr = 16'h0000;
      for (int k = 0; k < 3; k++) begin
        for (int c = 1; c <= 3; c++) begin
          @(negedge clk);
          chk($sformatf("b2b%0d c%0d dv", k, c), l4_dv, 1'b0);
          chk($sformatf("b2b%0d c%0d ready", k, c), l4_rdy, 1'b0);
        end
        @(negedge clk);
        chk($sformatf("b2b%0d dv", k), l4_dv, 1'b1);
        chk($sformatf("b2b%0d dout", k), l4_dout, b2b_exp[k]);
        if (k < 2) begin
          l4_addr = 16'((k + 1) * 2);
        end else begin
          l4_en = 1'b0;
        end
      end
      @(negedge clk);
      chk("b2b tail dv", l4_dv, 1'b0);
      chk("b2b tail ready", l4_rdy, 1'b1);
    end

    // Write attempted while busy must be dropped.
    l4_en = 1'b1; l4_wr = 1'b0; l4_addr = 16'h0020;
    @(negedge clk);
    chk("ign c1 ready", l4_rdy, 1'b0);
    l4_en = 1'b1; l4_wr = 1'b1; l4_din = 16'hDEAD;
    @(negedge clk);
    l4_en = 1'b0; l4_wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ign c4 dv", l4_dv, 1'b1);
    chk("ign c4 dout", l4_dout, 16'h7777);
    @(negedge clk);
    chk("ign c5 dv", l4_dv, 1'b0);
    txn4(1'b0, 16'h0020, 16'h0000, 16'h7777, "ign reread");

    // Reset while a write is outstanding.
    l4_en = 1'b1; l4_wr = 1'b1; l4_addr = 16'h0030; l4_din = 16'h1234;
    @(negedge clk);
    l4_en = 1'b0; l4_wr = 1'b0;
    chk("rst pre busy", l4_busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst ready", l4_rdy, 1'b1);
    chk("rst busy", l4_busy, 1'b0);
    chk("rst dv", l4_dv, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post rst dv", l4_dv, 1'b0);
      chk("post rst ready", l4_rdy, 1'b1);
    end
    txn4(1'b0, 16'h0030, 16'h0000, 16'h1234, "rst reread");

    // LATENCY=1: continuous enable, a response every cycle.
    begin
      logic        s_wr   [4];
      logic [15:0] s_addr [4];
      logic [15:0] s_din  [4];
      logic [15:0] s_exp  [4];
      s_wr[0] = 1'b1; s_addr[0] = 16'h0030; s_din[0] = 16'h1234; s_exp[0] = 16'h0000;
      s_wr[1] = 1'b1; s_addr[1] = 16'h0032; s_din[1] = 16'h4321; s_exp[1] = 16'h0000;
      s_wr[2] = 1'b0; s_addr[2] = 16'h0030; s_din[2] = 16'h0000; s_exp[2] = 16'h1234;
      s_wr[3] = 1'b0; s_addr[3] = 16'h0033; s_din[3] = 16'h0000; s_exp[3] = 16'h4321;
      for (int i = 0; i < 4; i++) begin
        l1_en = 1'b1; l1_wr = s_wr[i]; l1_addr = s_addr[i]; l1_din = s_din[i];
        @(negedge clk);
        chk($sformatf("lat1 s%0d dv", i), l1_dv, 1'b1);
        chk($sformatf("lat1 s%0d ready", i), l1_rdy, 1'b1);
        chk($sformatf("lat1 s%0d busy", i), l1_busy, 1'b0);
        chk($sformatf("lat1 s%0d dout", i), l1_dout, s_exp[i]);
      end
      l1_en = 1'b0;
      @(negedge clk);
      chk("lat1 tail dv", l1_dv, 1'b0);
      chk("lat1 tail ready", l1_rdy, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
